tdc_shot_sequencer: RTL and testbench
=====================================

Name: tdc_shot_sequencer

Overview:
Frame-level controller for the SPAD/TDC/histogram ranging chain. On a start request it issues a programmed number of periodic single-cycle TDC_start pulses to tdc_top, then waits for the histogram block to publish its peak depth. It returns that depth, or a timeout marker, to core logic over a valid/ready handshake. It replaces free-running start generation with a bounded, abortable, per-frame schedule.

Parameters:
CNT_W, 20, width of the period counter and the cfg_period / cfg_offset fields
SHOT_W, 16, width of the shot counter and the cfg_shots field
TO_CYC, 4096, DRAIN timeout in clk_i cycles
DATA_W, 15, depth word width; matches TDC_Odata / HIS_Odata

Ports:
clk_i  in  1  sequencer clock
rst  in  1  asynchronous reset, active low
seq_start  in  1  single-cycle frame request from core logic
seq_abort  in  1  single-cycle abort request
cfg_period  in  CNT_W  shot period minus 1, in clk_i cycles
cfg_offset  in  CNT_W  cycle within the period at which the start pulse fires
cfg_shots  in  SHOT_W  number of shots per frame
tdc_busy  in  1  busy flag from tdc_top
his_ovalid  in  1  histogram result valid
his_odata  in  DATA_W  histogram peak depth
his_oready  out  1  ready toward histogram
tdc_start  out  1  single-cycle start pulse to tdc_top
frame_valid  out  1  frame result valid
frame_data  out  DATA_W  frame depth; all-ones on timeout
frame_ready  in  1  core logic accepts the frame
seq_busy  out  1  high in any state other than IDLE
shot_cnt  out  SHOT_W  shots issued in the current frame
timeout_err  out  1  sticky; set by a DRAIN timeout, cleared by the next accepted seq_start

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs are 0, frame_data is 0, state is IDLE.
  - Period counter, shot counter and timeout counter are cleared.
- FSM states: IDLE, RUN, DRAIN, OUT. All outputs are registered.
- IDLE:
  - seq_start latches the configuration and clears shot_cnt and timeout_err; the FSM then moves to RUN.
  - At latch time, cfg_shots = 0 is treated as 1.
  - At latch time, cfg_offset > cfg_period is replaced with offset 0.
  - seq_start in any other state is ignored.
- RUN:
  - period_cnt counts 0..per, then wraps to 0; the first RUN cycle has period_cnt = 0.
  - When period_cnt == off and shot_cnt < shots, tdc_start is high on the following cycle for exactly 1 cycle, and shot_cnt increments in that same cycle.
  - When period_cnt == per and shot_cnt == shots, the FSM moves to DRAIN. The final period therefore always completes, giving the TDC its full range window.
  - his_oready = 0.
  - per = 0 is legal: one shot per cycle, with back-to-back tdc_start pulses.
- DRAIN:
  - his_oready = 1; the timeout counter increments each cycle.
  - When his_ovalid is high, frame_data is set to his_odata and the FSM moves to OUT; his_oready drops in the same cycle.
  - When the timeout counter reaches TO_CYC-1 with no his_ovalid, frame_data is set to all-ones (0x7FFF), timeout_err is set, and the FSM moves to OUT.
  - If his_ovalid arrives in the timeout cycle, the valid data wins.
- OUT:
  - frame_valid stays high and frame_data is held stable until frame_ready is sampled high. The FSM then returns to IDLE and frame_valid drops on the next cycle.
- seq_abort:
  - Highest priority in every state except IDLE: the next state is IDLE.
  - tdc_start, his_oready and frame_valid go to 0 and the counters are cleared.
  - No frame is produced; timeout_err is unchanged.
  - In IDLE, seq_abort has no effect.
  - If seq_abort and seq_start are high in the same IDLE cycle, seq_start wins.
- Widths: counters saturate at no point; the wrap is explicit at per, and shot_cnt never exceeds shots.

Optional Feature:
Macro: SEQ_BUSY_SKIP_EN
- Defined:
  - A start slot (period_cnt == off) that sees tdc_busy = 1 is skipped: no pulse, and shot_cnt does not advance. The frame lengthens by whole periods until shots real pulses have been issued.
  - An extra output port skip_cnt [SHOT_W-1:0] counts the skipped slots; it is cleared on frame start and saturates at all-ones.
- Not defined: tdc_busy is ignored, every slot issues a pulse, and the skip_cnt port does not exist.

Test Plan:
- Normal frame: per=640, off=10, shots=3 → tdc_start pulses at RUN cycles 11, 652 and 1293; DRAIN entered at cycle 1923; his_ovalid with 0x1234 → frame_valid with frame_data 0x1234, held until frame_ready.
- Timeout: shots=1, histogram silent → after TO_CYC DRAIN cycles, frame_data = 0x7FFF and timeout_err = 1; the next seq_start clears timeout_err.
- Boundaries: shots=0 gives exactly 1 pulse; per=0 with shots=4 gives 4 consecutive tdc_start cycles; off=50 with per=20 gives pulses at cycle 1 of each period.
- Abort: seq_abort in mid-RUN after 2 of 5 shots → next cycle IDLE, seq_busy = 0, no further tdc_start, no frame_valid.
- Backpressure and priority: frame_ready held low for 100 cycles → frame_data stable; seq_start during RUN is ignored; seq_start and seq_abort together in IDLE → frame starts.
- SEQ_BUSY_SKIP_EN: shots=3 with tdc_busy high during the second slot → 3 pulses across 4 periods and skip_cnt = 1.

Source files
------------

// File: rtl/tdc_shot_sequencer_if.sv
// Histogram-result and frame-result handshakes of the TDC shot sequencer.
// The master side is the sequencer. The slave side is the histogram source and the core-logic sink.
interface tdc_shot_sequencer_if #(
  parameter int DATA_W = 15
);
  logic              his_ovalid;
  logic [DATA_W-1:0] his_odata;
  logic              his_oready;
  logic              frame_valid;
  logic [DATA_W-1:0] frame_data;
  logic              frame_ready;

  modport master (
    input  his_ovalid, his_odata, frame_ready,
    output his_oready, frame_valid, frame_data
  );

  modport slave (
    output his_ovalid, his_odata, frame_ready,
    input  his_oready, frame_valid, frame_data
  );
endinterface

// File: rtl/tdc_shot_sequencer.sv
// Frame-level TDC start scheduler: periodic start pulses, histogram drain with timeout, result handshake.
// Optional build macro SEQ_BUSY_SKIP_EN: skip start slots while tdc_busy is high and add a skip_cnt port.
module tdc_shot_sequencer #(
  parameter int CNT_W  = 20,
  parameter int SHOT_W = 16,
  parameter int TO_CYC = 4096,
  parameter int DATA_W = 15
) (
  input  logic                 clk_i,
  input  logic                 rst,
  input  logic                 seq_start,
  input  logic                 seq_abort,
  input  logic [CNT_W-1:0]     cfg_period,
  input  logic [CNT_W-1:0]     cfg_offset,
  input  logic [SHOT_W-1:0]    cfg_shots,
  input  logic                 tdc_busy,
  tdc_shot_sequencer_if.master seq_if,
  output logic                 tdc_start,
  output logic                 seq_busy,
  output logic [SHOT_W-1:0]    shot_cnt,
  output logic                 timeout_err
`ifdef SEQ_BUSY_SKIP_EN
  ,
  output logic [SHOT_W-1:0]    skip_cnt
`endif
);

  localparam int TO_W = $clog2(TO_CYC + 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TO_CYC - 1);
  localparam logic [TO_W-1:0]   TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [SHOT_W-1:0] SHOT_ONE = {{(SHOT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_per;
  logic [CNT_W-1:0]    r_off;
  logic [CNT_W-1:0]    r_period_cnt;
  logic [SHOT_W-1:0]   r_shots;
  logic [SHOT_W-1:0]   r_shot_cnt;
  logic [TO_W-1:0]     r_to_cnt;
  logic                r_tdc_start;
  logic                r_his_oready;
  logic                r_frame_valid;
  logic                r_seq_busy;
  logic                r_timeout_err;
  logic [DATA_W-1:0]   r_frame_data;

  logic w_start_acc;
  logic w_abort;
  logic w_slot;
  logic w_fire;
  logic w_run_done;
  logic w_his_take;
  logic w_to_hit;

  assign w_start_acc = (r_state == S_IDLE) && seq_start;
  assign w_abort     = (r_state != S_IDLE) && seq_abort;
  assign w_slot      = (r_state == S_RUN) && (r_period_cnt == r_off) && (r_shot_cnt < r_shots);
  // The last period always runs to its end so the final shot gets a full range window.
  assign w_run_done  = (r_period_cnt == r_per) && (r_shot_cnt == r_shots);
  assign w_his_take  = (r_state == S_DRAIN) && seq_if.his_ovalid;
  assign w_to_hit    = (r_state == S_DRAIN) && !seq_if.his_ovalid && (r_to_cnt == TO_LAST);

`ifdef SEQ_BUSY_SKIP_EN
  assign w_fire = w_slot && !tdc_busy;
`else
  logic w_unused_busy;
  assign w_unused_busy = tdc_busy;
  assign w_fire = w_slot;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort outranks everything once a frame is in flight.
  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (seq_start) w_state_nxt = S_RUN;
          else           w_state_nxt = S_IDLE;
        end
        S_RUN: begin
          if (w_run_done) w_state_nxt = S_DRAIN;
          else            w_state_nxt = S_RUN;
        end
        S_DRAIN: begin
          if (seq_if.his_ovalid || w_to_hit) w_state_nxt = S_OUT;
          else                               w_state_nxt = S_DRAIN;
        end
        S_OUT: begin
          if (seq_if.frame_ready) w_state_nxt = S_IDLE;
          else                    w_state_nxt = S_OUT;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Registered outputs, latched configuration and frame counters.
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      r_per         <= {CNT_W{1'b0}};
      r_off         <= {CNT_W{1'b0}};
      r_shots       <= {SHOT_W{1'b0}};
      r_period_cnt  <= {CNT_W{1'b0}};
      r_shot_cnt    <= {SHOT_W{1'b0}};
      r_to_cnt      <= {TO_W{1'b0}};
      r_tdc_start   <= 1'b0;
      r_his_oready  <= 1'b0;
      r_frame_valid <= 1'b0;
      r_seq_busy    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_frame_data  <= {DATA_W{1'b0}};
    end else begin
      r_tdc_start   <= (w_state_nxt == S_RUN) && w_fire;
      r_his_oready  <= (w_state_nxt == S_DRAIN);
      r_frame_valid <= (w_state_nxt == S_OUT);
      r_seq_busy    <= (w_state_nxt != S_IDLE);
      if (w_start_acc) begin
        r_per         <= cfg_period;
        r_off         <= (cfg_offset > cfg_period) ? {CNT_W{1'b0}} : cfg_offset;
        r_shots       <= (cfg_shots == {SHOT_W{1'b0}}) ? SHOT_ONE : cfg_shots;
        r_period_cnt  <= {CNT_W{1'b0}};
        r_shot_cnt    <= {SHOT_W{1'b0}};
        r_to_cnt      <= {TO_W{1'b0}};
        r_timeout_err <= 1'b0;
      end else if (w_abort) begin
        r_period_cnt  <= {CNT_W{1'b0}};
        r_shot_cnt    <= {SHOT_W{1'b0}};
        r_to_cnt      <= {TO_W{1'b0}};
      end else begin
        if (r_state == S_RUN) begin
          r_period_cnt <= (r_period_cnt == r_per) ? {CNT_W{1'b0}} : (r_period_cnt + CNT_ONE);
        end else begin
          r_period_cnt <= {CNT_W{1'b0}};
        end
        if (w_fire) begin
          r_shot_cnt <= r_shot_cnt + SHOT_ONE;
        end else begin
          r_shot_cnt <= r_shot_cnt;
        end
        if (r_state == S_DRAIN) begin
          r_to_cnt <= r_to_cnt + TO_ONE;
        end else begin
          r_to_cnt <= {TO_W{1'b0}};
        end
        // Valid histogram data takes precedence over a coincident timeout.
        if (w_his_take) begin
          r_frame_data <= seq_if.his_odata;
        end else if (w_to_hit) begin
          r_frame_data  <= {DATA_W{1'b1}};
          r_timeout_err <= 1'b1;
        end else begin
          r_frame_data <= r_frame_data;
        end
      end
    end
  end

`ifdef SEQ_BUSY_SKIP_EN
  logic [SHOT_W-1:0] r_skip_cnt;

  // Saturating count of start slots skipped because the TDC was still busy.
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      r_skip_cnt <= {SHOT_W{1'b0}};
    end else if (w_start_acc) begin
      r_skip_cnt <= {SHOT_W{1'b0}};
    end else if (!w_abort && w_slot && tdc_busy && (r_skip_cnt != {SHOT_W{1'b1}})) begin
      r_skip_cnt <= r_skip_cnt + SHOT_ONE;
    end else begin
      r_skip_cnt <= r_skip_cnt;
    end
  end

  assign skip_cnt = r_skip_cnt;
`endif

  assign tdc_start          = r_tdc_start;
  assign seq_busy           = r_seq_busy;
  assign shot_cnt           = r_shot_cnt;
  assign timeout_err        = r_timeout_err;
  assign seq_if.his_oready  = r_his_oready;
  assign seq_if.frame_valid = r_frame_valid;
  assign seq_if.frame_data  = r_frame_data;

endmodule

// File: tb/tb_tdc_shot_sequencer.sv
// Directed self-checking bench for tdc_shot_sequencer; cycle numbers count from the first RUN cycle (0).
module tb_tdc_shot_sequencer;
  localparam int CNT_W  = 20;
  localparam int SHOT_W = 16;
  localparam int TO_CYC = 4096;
  localparam int DATA_W = 15;

  logic              clk_i = 1'b0;
  logic              rst;
  logic              seq_start;
  logic              seq_abort;
  logic [CNT_W-1:0]  cfg_period;
  logic [CNT_W-1:0]  cfg_offset;
  logic [SHOT_W-1:0] cfg_shots;
  logic              tdc_busy;
  logic              tdc_start;
  logic              seq_busy;
  logic [SHOT_W-1:0] shot_cnt;
  logic              timeout_err;
`ifdef SEQ_BUSY_SKIP_EN
  logic [SHOT_W-1:0] skip_cnt;
`endif

  tdc_shot_sequencer_if #(.DATA_W(DATA_W)) sif ();

  tdc_shot_sequencer #(
    .CNT_W(CNT_W), .SHOT_W(SHOT_W), .TO_CYC(TO_CYC), .DATA_W(DATA_W)
  ) dut (
    .clk_i(clk_i), .rst(rst), .seq_start(seq_start), .seq_abort(seq_abort),
    .cfg_period(cfg_period), .cfg_offset(cfg_offset), .cfg_shots(cfg_shots),
    .tdc_busy(tdc_busy), .seq_if(sif), .tdc_start(tdc_start), .seq_busy(seq_busy),
    .shot_cnt(shot_cnt), .timeout_err(timeout_err)
`ifdef SEQ_BUSY_SKIP_EN
    , .skip_cnt(skip_cnt)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int np;
  int drain_at;
  int pulse_at [8];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic start_frame(input int per, input int off, input int shots);
    cfg_period = CNT_W'(per);
    cfg_offset = CNT_W'(off);
    cfg_shots  = SHOT_W'(shots);
    seq_start  = 1'b1;
    tick();
    seq_start  = 1'b0;
  endtask

  // Runs RUN until his_oready rises, logging pulse cycles; optional start poke and busy slot.
  task automatic watch(input int budget, input int poke_at, input int busy_at);
    np = 0;
    drain_at = -1;
    for (int i = 0; i < 8; i++) pulse_at[i] = -1;
    for (int c = 0; c < budget; c++) begin
      if (sif.his_oready) begin
        drain_at = c;
        break;
      end
      if (tdc_start) begin
        if (np < 8) pulse_at[np] = c;
        np++;
      end
      seq_start = (c == poke_at);
      if (c == poke_at) cfg_shots = SHOT_W'(9);
      tdc_busy  = (c == busy_at);
      tick();
    end
    seq_start = 1'b0;
    tdc_busy  = 1'b0;
    if (drain_at < 0) check_eq("drain_reached", 32'd0, 32'd1);
  endtask

  task automatic finish_frame(input logic [DATA_W-1:0] data);
    sif.his_ovalid = 1'b1;
    sif.his_odata  = data;
    tick();
    sif.his_ovalid = 1'b0;
    check_eq("fin_valid", 32'(sif.frame_valid), 32'd1);
    check_eq("fin_data", 32'(sif.frame_data), 32'(data));
    sif.frame_ready = 1'b1;
    tick();
    sif.frame_ready = 1'b0;
    check_eq("fin_valid_drop", 32'(sif.frame_valid), 32'd0);
  endtask

  initial begin
    int changes;
    int pulses;
    int fvs;
    rst = 1'b0;
    seq_start = 1'b0;
    seq_abort = 1'b0;
    cfg_period = '0;
    cfg_offset = '0;
    cfg_shots = '0;
    tdc_busy = 1'b0;
    sif.his_ovalid = 1'b0;
    sif.his_odata = '0;
    sif.frame_ready = 1'b0;
    tick();
    tick();
    check_eq("rst_tdc_start", 32'(tdc_start), 32'd0);
    check_eq("rst_seq_busy", 32'(seq_busy), 32'd0);
    check_eq("rst_shot_cnt", 32'(shot_cnt), 32'd0);
    check_eq("rst_timeout_err", 32'(timeout_err), 32'd0);
    check_eq("rst_frame_valid", 32'(sif.frame_valid), 32'd0);
    check_eq("rst_frame_data", 32'(sif.frame_data), 32'd0);
    check_eq("rst_his_oready", 32'(sif.his_oready), 32'd0);
    rst = 1'b1;
    tick();

    // Normal frame with backpressure.
    start_frame(640, 10, 3);
    check_eq("norm_busy", 32'(seq_busy), 32'd1);
    watch(3000, -1, -1);
    check_eq("norm_np", 32'(np), 32'd3);
    check_eq("norm_p0", 32'(pulse_at[0]), 32'd11);
    check_eq("norm_p1", 32'(pulse_at[1]), 32'd652);
    check_eq("norm_p2", 32'(pulse_at[2]), 32'd1293);
    check_eq("norm_drain", 32'(drain_at), 32'd1923);
    check_eq("norm_shot_cnt", 32'(shot_cnt), 32'd3);
    sif.his_ovalid = 1'b1;
    sif.his_odata  = 15'h1234;
    tick();
    sif.his_ovalid = 1'b0;
    sif.his_odata  = 15'h0555;
    check_eq("norm_valid", 32'(sif.frame_valid), 32'd1);
    check_eq("norm_data", 32'(sif.frame_data), 32'h1234);
    check_eq("norm_oready_drop", 32'(sif.his_oready), 32'd0);
    changes = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (sif.frame_data !== 15'h1234 || sif.frame_valid !== 1'b1) changes++;
    end
    check_eq("norm_hold_stable", 32'(changes), 32'd0);
    sif.frame_ready = 1'b1;
    tick();
    sif.frame_ready = 1'b0;
    check_eq("norm_valid_drop", 32'(sif.frame_valid), 32'd0);
    check_eq("norm_idle", 32'(seq_busy), 32'd0);

    // Silent histogram: timeout after TO_CYC drain cycles.
    start_frame(3, 0, 1);
    watch(100, -1, -1);
    check_eq("to_drain", 32'(drain_at), 32'd4);
    for (int i = 0; i < TO_CYC - 1; i++) tick();
    check_eq("to_not_yet", 32'(sif.frame_valid), 32'd0);
    tick();
    check_eq("to_valid", 32'(sif.frame_valid), 32'd1);
    check_eq("to_data", 32'(sif.frame_data), 32'h7FFF);
    check_eq("to_err", 32'(timeout_err), 32'd1);
    sif.frame_ready = 1'b1;
    tick();
    sif.frame_ready = 1'b0;
    check_eq("to_err_sticky", 32'(timeout_err), 32'd1);

    // shots=0 acts as 1; seq_start during RUN ignored; start clears timeout_err.
    start_frame(5, 2, 0);
    check_eq("clr_err", 32'(timeout_err), 32'd0);
    watch(100, 1, -1);
    check_eq("s0_np", 32'(np), 32'd1);
    check_eq("s0_p0", 32'(pulse_at[0]), 32'd3);
    check_eq("s0_drain", 32'(drain_at), 32'd6);
    check_eq("s0_shot_cnt", 32'(shot_cnt), 32'd1);
    finish_frame(15'h0101);

    // per=0: back-to-back pulses.
    start_frame(0, 0, 4);
    watch(100, -1, -1);
    check_eq("p0_np", 32'(np), 32'd4);
    check_eq("p0_first", 32'(pulse_at[0]), 32'd1);
    check_eq("p0_last", 32'(pulse_at[3]), 32'd4);
    check_eq("p0_drain", 32'(drain_at), 32'd5);
    finish_frame(15'h0202);

    // Offset beyond period collapses to 0.
    start_frame(20, 50, 2);
    watch(200, -1, -1);
    check_eq("off_np", 32'(np), 32'd2);
    check_eq("off_p0", 32'(pulse_at[0]), 32'd1);
    check_eq("off_p1", 32'(pulse_at[1]), 32'd22);
    check_eq("off_drain", 32'(drain_at), 32'd42);
    finish_frame(15'h0303);

    // Abort after 2 of 5 shots.
    start_frame(9, 3, 5);
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      if (tdc_start) pulses++;
      tick();
    end
    check_eq("ab_pre_shots", 32'(shot_cnt), 32'd2);
    check_eq("ab_pre_pulses", 32'(pulses), 32'd2);
    seq_abort = 1'b1;
    tick();
    seq_abort = 1'b0;
    check_eq("ab_busy", 32'(seq_busy), 32'd0);
    check_eq("ab_shot_cnt", 32'(shot_cnt), 32'd0);
    pulses = 0;
    fvs = 0;
    for (int c = 0; c < 100; c++) begin
      if (tdc_start) pulses++;
      if (sif.frame_valid) fvs++;
      tick();
    end
    check_eq("ab_no_pulse", 32'(pulses), 32'd0);
    check_eq("ab_no_frame", 32'(fvs), 32'd0);
    check_eq("ab_err_kept", 32'(timeout_err), 32'd0);

    // Start and abort together in IDLE: start wins; then valid wins on the timeout cycle.
    cfg_period = CNT_W'(2);
    cfg_offset = CNT_W'(1);
    cfg_shots  = SHOT_W'(1);
    seq_start  = 1'b1;
    seq_abort  = 1'b1;
    tick();
    seq_start  = 1'b0;
    seq_abort  = 1'b0;
    check_eq("sa_busy", 32'(seq_busy), 32'd1);
    watch(100, -1, -1);
    check_eq("sa_p0", 32'(pulse_at[0]), 32'd2);
    check_eq("sa_drain", 32'(drain_at), 32'd3);
    for (int i = 0; i < TO_CYC - 1; i++) tick();
    check_eq("vw_not_yet", 32'(sif.frame_valid), 32'd0);
    finish_frame(15'h0ABC);
    check_eq("vw_no_err", 32'(timeout_err), 32'd0);

`ifdef SEQ_BUSY_SKIP_EN
    // Busy second slot is skipped; frame stretches by one period.
    start_frame(9, 3, 3);
    watch(200, -1, 13);
    check_eq("sk_np", 32'(np), 32'd3);
    check_eq("sk_p1", 32'(pulse_at[1]), 32'd24);
    check_eq("sk_p2", 32'(pulse_at[2]), 32'd34);
    check_eq("sk_drain", 32'(drain_at), 32'd40);
    check_eq("sk_cnt", 32'(skip_cnt), 32'd1);
    finish_frame(15'h0404);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
